// File: rtl/dadda_mul_pipe.sv
// Pipelined Dadda-tree multiplier: partial products reduced to two rows, registered, then a
// ripple final adder feeding y (optionally through an output register). Signed mode: DADDA_SIGNED_EN.
module dadda_mul_pipe #(
    parameter int WIDTH  = 8,
    parameter int OUTREG = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y
`ifdef DADDA_SIGNED_EN
    ,
    input  logic               tc
`endif
);
    localparam int NCOL = 2 * WIDTH;
    localparam int MAXH = WIDTH + 1;
    localparam int NSTG = 6;
    localparam int AW   = $clog2(WIDTH);
    localparam int CW   = $clog2(NCOL);
    localparam int HW   = $clog2(MAXH);

    // Dadda height targets, largest first; stages whose target exceeds every column are no-ops.
    function automatic int dseq(input int s);
        case (s)
            0:       dseq = 13;
            1:       dseq = 9;
            2:       dseq = 6;
            3:       dseq = 4;
            4:       dseq = 3;
            default: dseq = 2;
        endcase
    endfunction

    logic [NCOL-1:0] sum_row_d, carry_row_d;

    always_comb begin : dadda_tree
        logic [MAXH-1:0] cur [NCOL];
        logic [MAXH-1:0] nxt [NCOL];
        int              cur_h [NCOL];
        int              nxt_h [NCOL];
        int              k;
        int              rem;
        logic            pp, x0, x1, x2, s_bit, c_bit;
        k = 0; rem = 0; pp = 1'b0; x0 = 1'b0; x1 = 1'b0; x2 = 1'b0; s_bit = 1'b0; c_bit = 1'b0;
        for (int i = 0; i < NCOL; i++) begin
            cur[CW'(i)] = '0; nxt[CW'(i)] = '0; cur_h[CW'(i)] = 0; nxt_h[CW'(i)] = 0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp = a[AW'(j)] & b[AW'(i)];
`ifdef DADDA_SIGNED_EN
                // Baugh-Wooley: products pairing exactly one sign bit are inverted in signed mode.
                if ((i == WIDTH-1) != (j == WIDTH-1)) pp = pp ^ tc;
`endif
                cur[CW'(i+j)][HW'(cur_h[CW'(i+j)])] = pp;
                cur_h[CW'(i+j)] = cur_h[CW'(i+j)] + 1;
            end
        end
`ifdef DADDA_SIGNED_EN
        cur[CW'(WIDTH)][HW'(cur_h[CW'(WIDTH)])] = tc;
        cur_h[CW'(WIDTH)] = cur_h[CW'(WIDTH)] + 1;
        cur[CW'(NCOL-1)][HW'(cur_h[CW'(NCOL-1)])] = tc;
        cur_h[CW'(NCOL-1)] = cur_h[CW'(NCOL-1)] + 1;
`endif
        for (int s = 0; s < NSTG; s++) begin
            for (int i = 0; i < NCOL; i++) begin
                nxt[CW'(i)] = '0; nxt_h[CW'(i)] = 0;
            end
            for (int i = 0; i < NCOL; i++) begin
                k = 0;
                for (int t = 0; t < MAXH; t++) begin
                    rem = cur_h[CW'(i)] - k;
                    if (rem + nxt_h[CW'(i)] > dseq(s) && rem >= 2) begin
                        x0 = cur[CW'(i)][HW'(k)];
                        x1 = cur[CW'(i)][HW'(k+1)];
                        x2 = (rem + nxt_h[CW'(i)] - dseq(s) >= 2 && rem >= 3) ? cur[CW'(i)][HW'(k+2)] : 1'b0;
                        k  = (rem + nxt_h[CW'(i)] - dseq(s) >= 2 && rem >= 3) ? k + 3 : k + 2;
                        s_bit = x0 ^ x1 ^ x2;
                        c_bit = (x0 & x1) | (x2 & (x0 ^ x1));
                        nxt[CW'(i)][HW'(nxt_h[CW'(i)])] = s_bit;
                        nxt_h[CW'(i)] = nxt_h[CW'(i)] + 1;
                        // The carry out of the top column is beyond 2*WIDTH bits and is dropped.
                        if (i + 1 < NCOL) begin
                            nxt[CW'(i+1)][HW'(nxt_h[CW'(i+1)])] = c_bit;
                            nxt_h[CW'(i+1)] = nxt_h[CW'(i+1)] + 1;
                        end
                    end
                end
                for (int t = 0; t < MAXH; t++) begin
                    if (t >= k && t < cur_h[CW'(i)]) begin
                        nxt[CW'(i)][HW'(nxt_h[CW'(i)])] = cur[CW'(i)][HW'(t)];
                        nxt_h[CW'(i)] = nxt_h[CW'(i)] + 1;
                    end
                end
            end
            cur   = nxt;
            cur_h = nxt_h;
        end
        for (int i = 0; i < NCOL; i++) begin
            sum_row_d[CW'(i)]   = cur[CW'(i)][0];
            carry_row_d[CW'(i)] = cur[CW'(i)][1];
        end
    end

    logic            s1_valid_q, s1_valid_d, s1_load;
    logic [NCOL-1:0] s1_sum_q, s1_carry_q;

    assign s1_load    = in_valid && in_ready;
    assign s1_valid_d = in_ready ? in_valid : s1_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_valid_q <= 1'b0;
        else        s1_valid_q <= s1_valid_d;
    end

    // tc only shapes the partial products, so the registered rows already carry its effect.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_sum_q   <= sum_row_d;
            s1_carry_q <= carry_row_d;
        end
    end

    logic [NCOL-1:0] fin_sum;

    always_comb begin : final_adder
        logic cy;
        cy      = 1'b0;
        fin_sum = '0;
        for (int i = 0; i < NCOL; i++) begin
            fin_sum[CW'(i)] = s1_sum_q[CW'(i)] ^ s1_carry_q[CW'(i)] ^ cy;
            cy = (s1_sum_q[CW'(i)] & s1_carry_q[CW'(i)]) | (cy & (s1_sum_q[CW'(i)] ^ s1_carry_q[CW'(i)]));
        end
    end

    generate
        if (OUTREG != 0) begin : g_outreg
            logic            s2_valid_q, s2_valid_d, s2_adv;
            logic [NCOL-1:0] y_q, y_d;

            assign s2_adv     = !s2_valid_q || out_ready;
            assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
            assign y_d        = (s2_adv && s1_valid_q) ? fin_sum : y_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    y_q        <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    y_q        <= y_d;
                end
            end

            assign in_ready  = !s1_valid_q || s2_adv;
            assign out_valid = s2_valid_q;
            assign y         = y_q;
        end else begin : g_noreg
            assign in_ready  = !s1_valid_q || out_ready;
            assign out_valid = s1_valid_q;
            assign y         = s1_valid_q ? fin_sum : '0;
        end
    endgenerate
endmodule
